// File: rtl/multi_alarm_clock_core_pkg.sv
// Shared types for the multi-alarm clock core.
//   ring_state_e : ring/snooze FSM states
//   hm_t         : hours (1..12) / minutes (0..59) / am_pm (0=AM) triple,
//                  used for both the time of day and every alarm register
//   hm_inc_hours : +1 hour with 12->1 wrap; 11->12 flips AM/PM
//   hm_inc_mins  : +1 minute with 59->0 wrap and no carry into hours
package clock_alarm_pkg;
  localparam int HOURS_W = 4;
  localparam int MINS_W  = 6;
  localparam int SECS_W  = 6;

  typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} ring_state_e;

  typedef struct packed {
    logic [HOURS_W-1:0] hours;
    logic [MINS_W-1:0]  mins;
    logic               am_pm;
  } hm_t;

  localparam hm_t HM_MIDNIGHT = '{hours: 4'd12, mins: 6'd0, am_pm: 1'b0};

  function automatic hm_t hm_inc_hours(hm_t t);
    hm_t r;
    r = t;
    r.hours = (t.hours == 4'd12) ? 4'd1 : t.hours + 4'd1;
    if (t.hours == 4'd11) r.am_pm = ~t.am_pm;
    return r;
  endfunction

  function automatic hm_t hm_inc_mins(hm_t t);
    hm_t r;
    r = t;
    r.mins = (t.mins == 6'd59) ? 6'd0 : t.mins + 6'd1;
    return r;
  endfunction
endpackage

// File: rtl/multi_alarm_clock_core_if.sv
// User-control / display bundle of the multi-alarm clock core.
//   master : panel side (drives set/edit/arm/stop/snooze, reads display)
//   slave  : core side
// Inputs : set_time, set_alarm, alarm_sel, hours_set, mins_set, alarm_en,
//          toggle_switch, snooze
// Outputs: hours_out, mins_out, am_pm_out, secs_out, ring_id, speaker_out
interface multi_alarm_clock_core_if #(
  parameter int NUM_ALARMS = 4,
  parameter int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
);
  logic                  set_time;
  logic                  set_alarm;
  logic [AW-1:0]         alarm_sel;
  logic                  hours_set;
  logic                  mins_set;
  logic [NUM_ALARMS-1:0] alarm_en;
  logic                  toggle_switch;
  logic                  snooze;
  logic [3:0]            hours_out;
  logic [5:0]            mins_out;
  logic                  am_pm_out;
  logic [5:0]            secs_out;
  logic [AW-1:0]         ring_id;
  logic                  speaker_out;

  modport master (
    output set_time, set_alarm, alarm_sel, hours_set, mins_set, alarm_en,
           toggle_switch, snooze,
    input  hours_out, mins_out, am_pm_out, secs_out, ring_id, speaker_out
  );
  modport slave (
    input  set_time, set_alarm, alarm_sel, hours_set, mins_set, alarm_en,
           toggle_switch, snooze,
    output hours_out, mins_out, am_pm_out, secs_out, ring_id, speaker_out
  );
endinterface

// File: rtl/multi_alarm_clock_core_ring_fsm.sv
// alarm_ring_fsm: IDLE/RING/SNOOZE controller with ring timeout and snooze
// countdown, both counted in sec_tick units.
// Ports: clk, reset_n (sync, active low), trigger_i, toggle_i, snooze_i,
//        sec_tick_i in; speaker_o (high in RING), state_o out.
// Macro MULTI_ALARM_SNOOZE_EN builds the SNOOZE state and its countdown;
// without it snooze_i is ignored.
module alarm_ring_fsm
  import clock_alarm_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trigger_i,
  input  logic        toggle_i,
  input  logic        snooze_i,
  input  logic        sec_tick_i,
  output logic        speaker_o,
  output ring_state_e state_o
);
  localparam int TW = $clog2(RING_TIMEOUT_S + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(RING_TIMEOUT_S);

  ring_state_e   state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;

`ifdef MULTI_ALARM_SNOOZE_EN
  localparam int CW = $clog2(SNOOZE_S + 1);
  localparam logic [CW-1:0] SNZ_LOAD = CW'(SNOOZE_S);
  logic [CW-1:0] cd_q, cd_d;
`else
  logic snooze_unused;
  assign snooze_unused = snooze_i | (SNOOZE_S == 0);
`endif

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
`ifdef MULTI_ALARM_SNOOZE_EN
    cd_d    = cd_q;
`endif
    case (state_q)
      IDLE: if (trigger_i) begin
        state_d = RING;
        tmo_d   = '0;
      end
      RING: begin
        // Triggers are ignored here; stop beats snooze beats timeout.
        if (toggle_i) state_d = IDLE;
`ifdef MULTI_ALARM_SNOOZE_EN
        else if (snooze_i) begin
          state_d = SNOOZE;
          cd_d    = SNZ_LOAD;
        end
`endif
        else if (sec_tick_i) begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TMO_MAX) state_d = IDLE;
        end
      end
`ifdef MULTI_ALARM_SNOOZE_EN
      SNOOZE: begin
        if (toggle_i) state_d = IDLE;
        else if (trigger_i) begin
          state_d = RING;
          tmo_d   = '0;
        end else if (sec_tick_i) begin
          cd_d = cd_q - CW'(1);
          if (cd_q <= CW'(1)) begin
            cd_d    = '0;
            state_d = RING;
            tmo_d   = '0;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmo_q   <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
      cd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
`ifdef MULTI_ALARM_SNOOZE_EN
      cd_q    <= cd_d;
`endif
    end
  end

  assign speaker_o = (state_q == RING);
  assign state_o   = state_q;
endmodule

// File: rtl/multi_alarm_clock_core.sv
// multi_alarm_clock_core: 12-hour time-of-day counter, NUM_ALARMS alarm
// registers with per-alarm arm bits, and a ring/snooze controller.
// Ports: clk, reset_n (sync, active low), bus (multi_alarm_clock_core_if.slave:
//        edit/arm/stop/snooze controls in; display, ring_id, speaker out).
// Macro MULTI_ALARM_SNOOZE_EN enables snooze (see alarm_ring_fsm).
module multi_alarm_clock_core
  import clock_alarm_pkg::*;
#(
  parameter int CLK_HZ         = 256,
  parameter int NUM_ALARMS     = 4,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300
) (
  input  logic                     clk,
  input  logic                     reset_n,
  multi_alarm_clock_core_if.slave  bus
);
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0]              presc_q, presc_d;
  logic [SECS_W-1:0]          secs_q, secs_d;
  hm_t                        time_q, time_d;
  hm_t [NUM_ALARMS-1:0]       alarm_q, alarm_d;
  logic                       sec_tick, sel_valid, any_match, match_q, trig_q, accept;
  logic [NUM_ALARMS-1:0]      match;
  logic [AW-1:0]              low_id, trig_id_q, ring_id_q;
  hm_t                        disp;
  ring_state_e                state;
  logic                       speaker;

  assign sel_valid = 32'(bus.alarm_sel) < 32'(NUM_ALARMS);
  // Prescaler is pinned to 0 while setting time, so no tick can escape then.
  assign sec_tick  = !bus.set_time && (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = presc_q;
    secs_d  = secs_q;
    time_d  = time_q;
    alarm_d = alarm_q;
    if (bus.set_time) begin
      presc_d = '0;
      secs_d  = '0;
      if (bus.hours_set) time_d = hm_inc_hours(time_d);
      if (bus.mins_set)  time_d = hm_inc_mins(time_d);
    end else begin
      presc_d = sec_tick ? '0 : presc_q + PW'(1);
      if (sec_tick) begin
        if (secs_q == 6'd59) begin
          secs_d = '0;
          time_d = hm_inc_mins(time_q);
          if (time_q.mins == 6'd59) time_d = hm_inc_hours(time_d);
        end else begin
          secs_d = secs_q + 6'd1;
        end
      end
      if (bus.set_alarm && sel_valid) begin
        if (bus.hours_set) alarm_d[bus.alarm_sel] = hm_inc_hours(alarm_d[bus.alarm_sel]);
        if (bus.mins_set)  alarm_d[bus.alarm_sel] = hm_inc_mins(alarm_d[bus.alarm_sel]);
      end
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_match
    assign match[i] = bus.alarm_en[i] && (alarm_q[i] == time_q) &&
                      (secs_q == '0) && !bus.set_time;
  end
  assign any_match = |match;

  always_comb begin
    low_id = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (match[i]) low_id = AW'(i);
  end

  // ring_id follows only triggers the FSM actually takes (IDLE, or SNOOZE
  // without a simultaneous stop); a ring in progress keeps its id.
  assign accept = trig_q && ((state == IDLE) || ((state == SNOOZE) && !bus.toggle_switch));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q   <= '0;
      secs_q    <= '0;
      time_q    <= HM_MIDNIGHT;
      alarm_q   <= {NUM_ALARMS{HM_MIDNIGHT}};
      match_q   <= 1'b0;
      trig_q    <= 1'b0;
      trig_id_q <= '0;
      ring_id_q <= '0;
    end else begin
      presc_q   <= presc_d;
      secs_q    <= secs_d;
      time_q    <= time_d;
      alarm_q   <= alarm_d;
      match_q   <= any_match;
      trig_q    <= any_match && !match_q;
      trig_id_q <= low_id;
      if (accept) ring_id_q <= trig_id_q;
    end
  end

  alarm_ring_fsm #(
    .RING_TIMEOUT_S (RING_TIMEOUT_S),
    .SNOOZE_S       (SNOOZE_S)
  ) u_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .trigger_i  (trig_q),
    .toggle_i   (bus.toggle_switch),
    .snooze_i   (bus.snooze),
    .sec_tick_i (sec_tick),
    .speaker_o  (speaker),
    .state_o    (state)
  );

  always_comb begin
    disp = time_q;
    if (bus.set_alarm && !bus.set_time && sel_valid) disp = alarm_q[bus.alarm_sel];
  end

  assign bus.hours_out   = disp.hours;
  assign bus.mins_out    = disp.mins;
  assign bus.am_pm_out   = disp.am_pm;
  assign bus.secs_out    = secs_q;
  assign bus.ring_id     = ring_id_q;
  assign bus.speaker_out = speaker;
endmodule
